// File: rtl/stall_controller_if.sv
// Hazard/stall control bundle between the pipeline datapath and stall_controller.
// StallCount exists only when STALL_PERF_CNT_EN is defined.
interface stall_controller_if;
  logic [4:0]  RegSource1D;
  logic [4:0]  RegSource2D;
  logic [4:0]  RegDestinE;
  logic        LoadE;
  logic        PCSrcE;
  logic        MulStartE;
  logic        MulDoneE;
  logic        StallF;
  logic        StallD;
  logic        StallE;
  logic        FlushD;
  logic        FlushE;
  logic        FlushM;
  logic        MulBusy;
  logic        MulTimeout;
`ifdef STALL_PERF_CNT_EN
  logic [15:0] StallCount;
`endif

  modport master (
    output RegSource1D, RegSource2D, RegDestinE, LoadE, PCSrcE, MulStartE, MulDoneE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy, MulTimeout
`ifdef STALL_PERF_CNT_EN
    , input StallCount
`endif
  );

  modport slave (
    input  RegSource1D, RegSource2D, RegDestinE, LoadE, PCSrcE, MulStartE, MulDoneE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy, MulTimeout
`ifdef STALL_PERF_CNT_EN
    , output StallCount
`endif
  );
endinterface

// File: rtl/stall_controller.sv
// Pipeline stall/flush controller: load-use stall, branch flush and multi-cycle op wait.
// Optional feature macro STALL_PERF_CNT_EN adds a saturating 16-bit stall-cycle counter.
module stall_controller #(
  parameter int unsigned MUL_TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               reset,
  stall_controller_if.slave  bus
);

  typedef enum logic {
    RUN     = 1'b0,
    MULWAIT = 1'b1
  } state_e;

  localparam logic [7:0] WCNT_LAST = 8'(MUL_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       mul_timeout_q, mul_timeout_d;
  logic       load_use;
  logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mul_busy;

  assign load_use = bus.LoadE && (bus.RegDestinE != 5'd0) &&
                    ((bus.RegDestinE == bus.RegSource1D) || (bus.RegDestinE == bus.RegSource2D));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      wcnt_q        <= 8'd0;
      mul_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      mul_timeout_q <= mul_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    mul_timeout_d = 1'b0;
    stall_f       = 1'b0;
    stall_d       = 1'b0;
    stall_e       = 1'b0;
    flush_d       = 1'b0;
    flush_e       = 1'b0;
    flush_m       = 1'b0;
    mul_busy      = 1'b0;
    case (state_q)
      RUN: begin
        // Issue wins over redirect and load-use; MulDoneE is meaningless here.
        if (bus.MulStartE) begin
          state_d = MULWAIT;
          wcnt_d  = 8'd0;
        end else if (bus.PCSrcE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      MULWAIT: begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_e  = 1'b1;
        flush_m  = 1'b1;
        mul_busy = 1'b1;
        // A result arriving on the last allowed cycle is a normal completion.
        if (bus.MulDoneE) begin
          state_d = RUN;
          wcnt_d  = 8'd0;
        end else if (wcnt_q == WCNT_LAST) begin
          state_d       = RUN;
          wcnt_d        = 8'd0;
          mul_timeout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = 8'd0;
      end
    endcase
  end

  // Controls are forced low for the whole reset window, not just after the edge.
  assign bus.StallF     = stall_f  & ~reset;
  assign bus.StallD     = stall_d  & ~reset;
  assign bus.StallE     = stall_e  & ~reset;
  assign bus.FlushD     = flush_d  & ~reset;
  assign bus.FlushE     = flush_e  & ~reset;
  assign bus.FlushM     = flush_m  & ~reset;
  assign bus.MulBusy    = mul_busy & ~reset;
  assign bus.MulTimeout = mul_timeout_q;

`ifdef STALL_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_f && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_stall_controller.sv
// Scoreboard bench for stall_controller (MUL_TIMEOUT=8); expectations come from a cycle model.
module tb_stall_controller;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stall_controller_if bus ();

  stall_controller #(.MUL_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0]  outs;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   busy_cnt = 0;
  int   to_cnt   = 0;

  // Reference model state
  bit   m_wait    = 1'b0;
  int   m_elapsed = 0;
  bit   m_to      = 1'b0;
  int   m_scnt    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Order: StallF StallD StallE FlushD FlushE FlushM MulBusy MulTimeout
  task automatic cyc(input logic r, input logic ld, input logic [4:0] rd, input logic [4:0] s1,
                     input logic [4:0] s2, input logic pc, input logic ms, input logic md);
    logic [7:0] o;
    bit lu;
    exp_t e;
    reset         = r;
    bus.LoadE     = ld;
    bus.RegDestinE  = rd;
    bus.RegSource1D = s1;
    bus.RegSource2D = s2;
    bus.PCSrcE    = pc;
    bus.MulStartE = ms;
    bus.MulDoneE  = md;
    lu = ld && (rd != 0) && (rd == s1 || rd == s2);
    o = 8'b0;
    if (!r) begin
      if (m_wait) o = 8'b1110_0110;
      else if (!ms && pc) o = 8'b0001_1000;
      else if (!ms && lu) o = 8'b1100_1000;
      o[0] = m_to;
    end
    e.outs = o;
    e.cnt  = r ? 16'd0 : 16'(m_scnt);
    sb.push_back(e);
    @(posedge clk);
    if (r) begin
      m_wait = 0; m_elapsed = 0; m_to = 0; m_scnt = 0;
    end else begin
      if (o[7] && m_scnt < 65535) m_scnt++;
      if (!m_wait) begin
        m_to = 0;
        if (ms) begin m_wait = 1; m_elapsed = 1; end
      end else if (md) begin
        m_wait = 0; m_to = 0;
      end else if (m_elapsed == TO) begin
        m_wait = 0; m_to = 1;
      end else begin
        m_elapsed++; m_to = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("outs", 32'({bus.StallF, bus.StallD, bus.StallE, bus.FlushD, bus.FlushE,
                       bus.FlushM, bus.MulBusy, bus.MulTimeout}), 32'(e.outs));
`ifdef STALL_PERF_CNT_EN
      chk("stall_count", 32'(bus.StallCount), 32'(e.cnt));
`endif
      busy_cnt += int'(bus.MulBusy);
      to_cnt   += int'(bus.MulTimeout);
    end
  end

  initial begin
    reset = 1'b1;
    bus.LoadE = 0; bus.RegDestinE = 0; bus.RegSource1D = 0; bus.RegSource2D = 0;
    bus.PCSrcE = 0; bus.MulStartE = 0; bus.MulDoneE = 0;
    @(posedge clk); #1;

    // Reset holds everything low even with hazard inputs present
    cyc(1, 1, 5, 5, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 0);
    idle(1);

    // Load-use on source 2, then on source 1: single-cycle stall each
    cyc(0, 1, 5, 0, 5, 0, 0, 0);
    idle(1);
    cyc(0, 1, 7, 7, 3, 0, 0, 0);
    cyc(0, 1, 7, 1, 2, 0, 0, 0);

    // x0 destination never stalls
    cyc(0, 1, 0, 0, 0, 0, 0, 0);

    // Branch beats load-use
    cyc(0, 1, 9, 9, 9, 1, 0, 0);
    idle(1);

    // Multi-cycle op finishing after 4 wait cycles
    busy_cnt = 0; to_cnt = 0;
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 4, 4, 0, 1, 0, 0);
    idle(2);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    chk("mul_busy_cycles", 32'(busy_cnt), 32'd4);
    chk("mul_no_timeout", 32'(to_cnt), 32'd0);

    // Timeout after exactly TO wait cycles with one pulse
    busy_cnt = 0; to_cnt = 0;
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    idle(TO + 3);
    chk("timeout_busy_cycles", 32'(busy_cnt), 32'(TO));
    chk("timeout_pulses", 32'(to_cnt), 32'd1);

    // Done on the last allowed cycle is a normal completion
    busy_cnt = 0; to_cnt = 0;
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    idle(TO - 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    chk("coincide_busy_cycles", 32'(busy_cnt), 32'(TO));
    chk("coincide_pulses", 32'(to_cnt), 32'd0);

    // Done during issue is ignored; wait lasts at least one cycle
    busy_cnt = 0;
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    chk("min_wait_cycles", 32'(busy_cnt), 32'd1);

    // Reset in the third wait cycle
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    chk("busy_before_reset", 32'(bus.MulBusy), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_immediate", 32'({bus.StallF, bus.StallD, bus.StallE, bus.FlushD, bus.FlushE,
                                bus.FlushM, bus.MulBusy, bus.MulTimeout}), 32'd0);
`ifdef STALL_PERF_CNT_EN
    chk("reset_stall_count", 32'(bus.StallCount), 32'd0);
`endif
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 6, 6, 0, 0, 0, 0);
    idle(2);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/stall_controller.md
STALL_CONTROLLER -- requirements
Module: stall_controller

Interface
REQ-001 The block SHALL have parameter MUL_TIMEOUT, default 32 (legal range 2..255): maximum MULWAIT cycles before forced exit.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the ports RegSource1D and RegSource2D, input, 5 bits each: source registers of the instruction in Decode.
REQ-005 The block SHALL have the port RegDestinE, input, 5 bits: destination register of the instruction in Execute.
REQ-006 The block SHALL have the port LoadE, input, 1 bit: the Execute instruction is a load.
REQ-007 The block SHALL have the port PCSrcE, input, 1 bit: a branch or jump is taken in Execute.
REQ-008 The block SHALL have the port MulStartE, input, 1 bit: a multi-cycle op is issued in Execute.
REQ-009 The block SHALL have the port MulDoneE, input, 1 bit: the multi-cycle unit has its result ready.
REQ-010 The block SHALL have the outputs StallF, StallD, StallE, FlushD, FlushE and FlushM, 1 bit each: pipeline register hold and clear controls.
REQ-011 The block SHALL have the output MulBusy, 1 bit: high while the FSM is in MULWAIT.
REQ-012 The block SHALL have the output MulTimeout, 1 bit: one-cycle pulse on forced exit from MULWAIT.

Function
REQ-013 The FSM SHALL have exactly two states, RUN and MULWAIT, and an 8-bit wait counter WCNT.
REQ-014 In RUN with MulStartE=1, the next state SHALL be MULWAIT with WCNT cleared to 0; PCSrcE and load-use SHALL be ignored that cycle.
REQ-015 In RUN with MulStartE=0 and PCSrcE=1, FlushD=FlushE=1 SHALL be driven in the same cycle; load-use stall SHALL be suppressed.
REQ-016 In RUN the load-use condition SHALL be LoadE=1, RegDestinE!=0, and (RegDestinE==RegSource1D or RegDestinE==RegSource2D).
REQ-017 When load-use holds and PCSrcE=0 and MulStartE=0, StallF=StallD=FlushE=1 SHALL be driven for that cycle only; the state SHALL remain RUN.
REQ-018 In MULWAIT, StallF=StallD=StallE=FlushM=1 and MulBusy=1 SHALL be driven combinationally; PCSrcE and load-use SHALL be ignored.
REQ-019 In MULWAIT with MulDoneE=1, the next state SHALL be RUN, with the stalls released on the following cycle.
REQ-020 In MULWAIT with MulDoneE=0, WCNT SHALL increment; when WCNT==MUL_TIMEOUT-1, the next state SHALL be RUN and MulTimeout SHALL pulse for 1 cycle.
REQ-021 When MulDoneE and timeout coincide, the exit SHALL count as a normal completion, with no MulTimeout pulse.
REQ-022 MulDoneE SHALL be ignored in RUN; MulDoneE in the issue cycle SHALL NOT shorten MULWAIT below 1 cycle.
REQ-023 All stall and flush outputs SHALL be combinational from the state and inputs (zero latency); only the state, WCNT and MulTimeout SHALL be registered.

Reset
REQ-024 On reset=1, the state SHALL go immediately to RUN, WCNT to 0 and MulTimeout to 0, including mid-MULWAIT.
REQ-025 While reset=1, all stall, flush, MulBusy and MulTimeout outputs SHALL be 0.

Configuration
REQ-026 With STALL_PERF_CNT_EN defined, the block SHALL add the output StallCount, 16 bits: it increments every cycle StallF=1, saturates at 16'hFFFF, and resets to 0.
REQ-027 Without STALL_PERF_CNT_EN, the StallCount port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Load-use test: LoadE=1, RegDestinE=5, RegSource2D=5 in RUN -> StallF=StallD=FlushE=1 for exactly 1 cycle.
REQ-029 x0 test: LoadE=1, RegDestinE=0, RegSource1D=0 -> no stall, no flush.
REQ-030 Multi-cycle test: MulStartE pulse, then MulDoneE after 4 cycles -> MulBusy and StallF/StallD/StallE/FlushM high for 4 cycles, then RUN, MulTimeout=0.
REQ-031 Timeout test: MUL_TIMEOUT=8, MulStartE with MulDoneE held 0 -> exit after 8 MULWAIT cycles with a single MulTimeout pulse.
REQ-032 Priority test: PCSrcE=1 together with load-use -> FlushD=FlushE=1 and StallF=0; PCSrcE=1 during MULWAIT -> no FlushD.
REQ-033 Reset test: reset asserted in the 3rd MULWAIT cycle -> outputs 0 immediately, and the FSM is in RUN after release; with STALL_PERF_CNT_EN defined, StallCount=0.
